sm_step_conditioner: RTL and testbench

Downstream stage of the tracking regulator. It takes the regulator's raw step, direction and motor-enable signals and turns them into driver-safe outputs with enforced enable wake-up, direction setup, and minimum high/low step pulse widths. It also queues one pending step request, counts dropped requests, blocks motion into active limit switches, and keeps a signed absolute position counter. Its outputs go straight to the external stepper driver pins.

---
 rtl/sm_step_conditioner.sv | 189 ++++++++++++++++++
 tb/tb_sm_step_conditioner.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sm_step_conditioner.sv
// Step/dir/enable conditioner for an external stepper driver: enforces enable wake-up,
// direction setup and pulse widths, queues one request, blocks limits, tracks position.
//
// state       | meaning
// S_DISABLED  | driver disabled, requests ignored
// S_WAKE      | driver enabled, waiting out enable setup
// S_IDLE      | ready, dispatches the pending request
// S_DIR_SETUP | dir_out changed, waiting before the pulse
// S_STEP_HIGH | step_out high, fixed width
// S_STEP_LOW  | step_out low, minimum gap
module sm_step_conditioner #(
  parameter int T_EN_SETUP  = 2500,
  parameter int T_DIR_SETUP = 250,
  parameter int T_HIGH      = 100,
  parameter int T_LOW       = 100,
  parameter int POS_WIDTH   = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 step_in,
  input  logic                 dir_in,
  input  logic                 sm_en_in,
  input  logic                 limit_fwd,
  input  logic                 limit_rev,
  input  logic                 pos_clr,
  output logic                 step_out,
  output logic                 dir_out,
  output logic                 en_out,
  output logic                 busy,
  output logic                 limit_hit,
  output logic [POS_WIDTH-1:0] pos,
  output logic [7:0]           drop_cnt
);

  localparam int CW = 16;
  localparam logic [CW-1:0]        LD_EN   = CW'(T_EN_SETUP - 1);
  localparam logic [CW-1:0]        LD_DIR  = CW'(T_DIR_SETUP - 1);
  localparam logic [CW-1:0]        LD_HIGH = CW'(T_HIGH - 1);
  localparam logic [CW-1:0]        LD_LOW  = CW'(T_LOW - 1);
  localparam logic [CW-1:0]        CNT_ONE = CW'(1);
  localparam logic [POS_WIDTH-1:0] POS_ONE = POS_WIDTH'(1);

  typedef enum logic [2:0] {
    S_DISABLED,
    S_WAKE,
    S_IDLE,
    S_DIR_SETUP,
    S_STEP_HIGH,
    S_STEP_LOW
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 step_q;
  logic                 pending_q, pending_d;
  logic                 dir_req_q, dir_req_d;
  logic                 dir_q, dir_d;
  logic                 dis_q, dis_d;
  logic                 limit_hit_q, limit_hit_d;
  logic [POS_WIDTH-1:0] pos_q, pos_d;
  logic [7:0]           drop_q, drop_d;
  logic                 rise;
  logic                 tc;
  logic                 consume;

  assign rise = step_in & ~step_q;
  assign tc   = (cnt_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_DISABLED;
      cnt_q       <= '0;
      step_q      <= 1'b0;
      pending_q   <= 1'b0;
      dir_req_q   <= 1'b0;
      dir_q       <= 1'b0;
      dis_q       <= 1'b0;
      limit_hit_q <= 1'b0;
      pos_q       <= '0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      step_q      <= step_in;
      pending_q   <= pending_d;
      dir_req_q   <= dir_req_d;
      dir_q       <= dir_d;
      dis_q       <= dis_d;
      limit_hit_q <= limit_hit_d;
      pos_q       <= pos_d;
      drop_q      <= drop_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = tc ? cnt_q : cnt_q - CNT_ONE;
    dir_d       = dir_q;
    dis_d       = 1'b0;
    limit_hit_d = 1'b0;
    consume     = 1'b0;
    pos_d       = pos_q;
    pending_d   = pending_q;
    dir_req_d   = dir_req_q;
    drop_d      = drop_q;

    unique case (state_q)
      S_DISABLED: begin
        if (sm_en_in) begin
          state_d = S_WAKE;
          cnt_d   = LD_EN;
        end
      end
      S_WAKE: begin
        if (!sm_en_in)  state_d = S_DISABLED;
        else if (tc)    state_d = S_IDLE;
      end
      S_IDLE: begin
        if (!sm_en_in) begin
          state_d = S_DISABLED;
        end else if (pending_q) begin
          consume = 1'b1;
          if ((dir_req_q && limit_fwd) || (!dir_req_q && limit_rev)) begin
            limit_hit_d = 1'b1;
          end else if (dir_req_q != dir_q) begin
            dir_d   = dir_req_q;
            state_d = S_DIR_SETUP;
            cnt_d   = LD_DIR;
          end else begin
            state_d = S_STEP_HIGH;
            cnt_d   = LD_HIGH;
          end
        end
      end
      S_DIR_SETUP: begin
        if (!sm_en_in) begin
          state_d = S_DISABLED;
        end else if (tc) begin
          state_d = S_STEP_HIGH;
          cnt_d   = LD_HIGH;
        end
      end
      S_STEP_HIGH: begin
        // a disable request is remembered so the pulse always completes
        dis_d = dis_q | ~sm_en_in;
        if (tc) begin
          if (dis_d) begin
            state_d = S_DISABLED;
          end else begin
            state_d = S_STEP_LOW;
            cnt_d   = LD_LOW;
          end
        end
      end
      S_STEP_LOW: begin
        if (!sm_en_in)  state_d = S_DISABLED;
        else if (tc)    state_d = S_IDLE;
      end
      default: state_d = S_DISABLED;
    endcase

    if (state_d == S_STEP_HIGH && state_q != S_STEP_HIGH)
      pos_d = dir_q ? pos_q + POS_ONE : pos_q - POS_ONE;
    if (pos_clr)
      pos_d = '0;

    if (consume)
      pending_d = 1'b0;
    if (rise && state_q != S_DISABLED) begin
      if (!pending_q || consume) begin
        pending_d = 1'b1;
        dir_req_d = dir_in;
      end else if (drop_q != 8'hFF) begin
        drop_d = drop_q + 8'd1;
      end
    end
    if (state_d == S_DISABLED)
      pending_d = 1'b0;
  end

  assign step_out  = (state_q == S_STEP_HIGH);
  assign dir_out   = dir_q;
  assign en_out    = (state_q != S_DISABLED);
  assign busy      = pending_q | (state_q inside {S_DIR_SETUP, S_STEP_HIGH, S_STEP_LOW});
  assign limit_hit = limit_hit_q;
  assign pos       = pos_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_sm_step_conditioner.sv
// Directed bench for sm_step_conditioner with short timing parameters;
// a pulse monitor checks every high width and low gap on step_out.
module tb_sm_step_conditioner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       step_in = 1'b0;
  logic       dir_in = 1'b0;
  logic       sm_en_in = 1'b0;
  logic       limit_fwd = 1'b0;
  logic       limit_rev = 1'b0;
  logic       pos_clr = 1'b0;
  logic       step_out, dir_out, en_out, busy, limit_hit;
  logic [7:0] pos;
  logic [7:0] drop_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  int pulse_cnt = 0;

  sm_step_conditioner #(
    .T_EN_SETUP (4),
    .T_DIR_SETUP(3),
    .T_HIGH     (2),
    .T_LOW      (2),
    .POS_WIDTH  (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .step_in  (step_in),
    .dir_in   (dir_in),
    .sm_en_in (sm_en_in),
    .limit_fwd(limit_fwd),
    .limit_rev(limit_rev),
    .pos_clr  (pos_clr),
    .step_out (step_out),
    .dir_out  (dir_out),
    .en_out   (en_out),
    .busy     (busy),
    .limit_hit(limit_hit),
    .pos      (pos),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_step(input logic d);
    step_in = 1'b1;
    dir_in  = d;
    cyc(1);
    step_in = 1'b0;
  endtask

  // pulse monitor: widths measured in negedge samples
  logic prev_step = 1'b0;
  int   hi_run = 0;
  int   lo_run = 0;
  bit   seen = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_step = 1'b0;
      hi_run    = 0;
      lo_run    = 0;
      seen      = 1'b0;
    end else begin
      if (step_out) begin
        if (!prev_step && seen) chk("low_gap_ge2", 32'(lo_run >= 2), 32'd1);
        hi_run++;
      end else begin
        if (prev_step) begin
          chk("high_width", 32'(hi_run), 32'd2);
          pulse_cnt++;
          seen   = 1'b1;
          hi_run = 0;
          lo_run = 0;
        end
        lo_run++;
      end
      prev_step = step_out;
    end
  end

  int p0;

  initial begin
    // reset state
    cyc(2);
    chk("rst_step_out", 32'(step_out), 32'd0);
    chk("rst_en_out", 32'(en_out), 32'd0);
    chk("rst_dir_out", 32'(dir_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pos", 32'(pos), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    rst = 1'b0;
    cyc(1);

    // wake-up, first step in reverse without direction setup
    sm_en_in = 1'b1;
    cyc(1);
    chk("wake_en_out", 32'(en_out), 32'd1);
    pulse_step(1'b0);
    chk("wake_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk("wake_no_step", 32'(step_out), 32'd0);
    end
    cyc(1);
    chk("wake_step_rise", 32'(step_out), 32'd1);
    chk("wake_pos_ff", 32'(pos), 32'h0FF);
    cyc(1);
    chk("wake_step_hold", 32'(step_out), 32'd1);
    cyc(1);
    chk("wake_step_fall", 32'(step_out), 32'd0);
    cyc(3);
    chk("wake_idle_busy", 32'(busy), 32'd0);

    // direction change: dir_out leads step_out by 3 cycles
    pulse_step(1'b1);
    chk("dir_before", 32'(dir_out), 32'd0);
    cyc(1);
    chk("dir_switched", 32'(dir_out), 32'd1);
    chk("dir_setup_busy", 32'(busy), 32'd1);
    cyc(2);
    chk("dir_setup_no_step", 32'(step_out), 32'd0);
    cyc(1);
    chk("dir_step_rise", 32'(step_out), 32'd1);
    chk("dir_pos_inc", 32'(pos), 32'h000);
    cyc(6);

    // overrun: first request needs direction setup, so edges 3..5 find the queue full
    p0 = pulse_cnt;
    for (int k = 0; k < 5; k++) begin
      pulse_step(1'b0);
      cyc(1);
    end
    cyc(8);
    chk("ovr_pulses", 32'(pulse_cnt - p0), 32'd2);
    chk("ovr_drop", 32'(drop_cnt), 32'd3);
    chk("ovr_pos", 32'(pos), 32'h0FE);
    chk("ovr_idle_busy", 32'(busy), 32'd0);

    // limit: forward blocked, reverse passes
    limit_fwd = 1'b1;
    p0 = pulse_cnt;
    pulse_step(1'b1);
    chk("lim_hit_pre", 32'(limit_hit), 32'd0);
    cyc(1);
    chk("lim_hit_pulse", 32'(limit_hit), 32'd1);
    cyc(1);
    chk("lim_hit_clear", 32'(limit_hit), 32'd0);
    cyc(4);
    chk("lim_no_pulse", 32'(pulse_cnt - p0), 32'd0);
    chk("lim_pos_hold", 32'(pos), 32'h0FE);
    chk("lim_dir_hold", 32'(dir_out), 32'd0);
    pulse_step(1'b0);
    cyc(7);
    chk("lim_rev_pulse", 32'(pulse_cnt - p0), 32'd1);
    chk("lim_rev_pos", 32'(pos), 32'h0FD);
    limit_fwd = 1'b0;

    // disable in the first STEP_HIGH cycle with a request queued behind it
    pulse_step(1'b0);
    cyc(1);
    chk("dis_first_high", 32'(step_out), 32'd1);
    sm_en_in = 1'b0;
    step_in  = 1'b1;
    dir_in   = 1'b0;
    cyc(1);
    step_in = 1'b0;
    chk("dis_second_high", 32'(step_out), 32'd1);
    chk("dis_en_still", 32'(en_out), 32'd1);
    chk("dis_busy_high", 32'(busy), 32'd1);
    cyc(1);
    chk("dis_step_low", 32'(step_out), 32'd0);
    chk("dis_en_off", 32'(en_out), 32'd0);
    chk("dis_busy_off", 32'(busy), 32'd0);
    chk("dis_pos", 32'(pos), 32'h0FC);
    cyc(3);
    chk("dis_no_resume", 32'(step_out | busy), 32'd0);

    // wrap 0x7F -> 0x80, clear vs step entry, async reset mid-pulse
    sm_en_in = 1'b1;
    pos_clr  = 1'b1;
    cyc(1);
    pos_clr = 1'b0;
    chk("clr_pos", 32'(pos), 32'd0);
    cyc(5);
    for (int k = 0; k < 127; k++) begin
      pulse_step(1'b1);
      cyc(9);
    end
    chk("wrap_pos_7f", 32'(pos), 32'h07F);
    pulse_step(1'b1);
    cyc(1);
    chk("wrap_step_high", 32'(step_out), 32'd1);
    chk("wrap_pos_80", 32'(pos), 32'h080);
    cyc(6);
    pulse_step(1'b1);
    pos_clr = 1'b1;
    cyc(1);
    pos_clr = 1'b0;
    chk("clr_vs_step_high", 32'(step_out), 32'd1);
    chk("clr_vs_step_pos", 32'(pos), 32'd0);
    cyc(6);
    pulse_step(1'b1);
    cyc(1);
    chk("rst_pre_high", 32'(step_out), 32'd1);
    chk("rst_pre_pos", 32'(pos), 32'd1);
    chk("rst_pre_drop", 32'(drop_cnt), 32'd3);
    #2 rst = 1'b1;
    #1;
    chk("arst_step_out", 32'(step_out), 32'd0);
    chk("arst_en_out", 32'(en_out), 32'd0);
    chk("arst_dir_out", 32'(dir_out), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_limit_hit", 32'(limit_hit), 32'd0);
    chk("arst_pos", 32'(pos), 32'd0);
    chk("arst_drop", 32'(drop_cnt), 32'd0);
    cyc(2);
    rst = 1'b0;
    cyc(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
